// File: rtl/game_sprite_spawn_ctrl_pkg.sv
// Shared types and helpers for sprite spawn controllers: sequencer states, LFSR constants, dx decode.
package game_spawn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_XY  = 3'd1,
        ST_LOAD_DXY = 3'd2,
        ST_ACTIVE   = 3'd3,
        ST_COOLDOWN = 3'd4
    } spawn_state_e;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return (state >> 1) ^ (state[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Two random bits give a horizontal drift biased towards straight-down motion.
    function automatic logic [1:0] dx_decode(input logic [1:0] sel);
        case (sel)
            2'b01:   return 2'b01;
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/game_sprite_spawn_ctrl_if.sv
// Handshake bundle between game logic, the spawn controller and one sprite instance.
interface game_sprite_spawn_ctrl_if #(
    parameter int W_X      = 10,
    parameter int W_Y      = 9,
    parameter int DX_WIDTH = 2,
    parameter int DY_WIDTH = 2
);
    logic                launch;
    logic                auto_respawn;
    logic                kill;
    logic                sprite_within_screen;
    logic                sprite_write_xy;
    logic                sprite_write_dxy;
    logic [W_X-1:0]      sprite_write_x;
    logic [W_Y-1:0]      sprite_write_y;
    logic [DX_WIDTH-1:0] sprite_write_dx;
    logic [DY_WIDTH-1:0] sprite_write_dy;
    logic                sprite_enable_update;
    logic                active;
    logic                miss;
    logic                kill_ack;
    logic [7:0]          spawn_count;

    modport master (
        input  launch, auto_respawn, kill, sprite_within_screen,
        output sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
               sprite_write_dx, sprite_write_dy, sprite_enable_update,
               active, miss, kill_ack, spawn_count
    );

    modport slave (
        output launch, auto_respawn, kill, sprite_within_screen,
        input  sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
               sprite_write_dx, sprite_write_dy, sprite_enable_update,
               active, miss, kill_ack, spawn_count
    );
endinterface

// File: rtl/game_sprite_spawn_ctrl_lfsr.sv
// Free-running 16-bit Galois LFSR; a zero seed would lock up, so it is swapped for the default.
module game_lfsr16
    import game_spawn_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state_o
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/game_sprite_spawn_ctrl.sv
// Spawn sequencer for one meteor sprite: place, launch, watch for exit or kill, cool down, respawn.
module game_sprite_spawn_ctrl
    import game_spawn_pkg::*;
#(
    parameter int          screen_width    = 640,
    parameter int          screen_height   = 480,
    parameter int          w_x             = $clog2(screen_width),
    parameter int          w_y             = $clog2(screen_height),
    parameter int          DX_WIDTH        = 2,
    parameter int          DY_WIDTH        = 2,
    parameter int          SPAWN_X_MIN     = 32,
    parameter int          X_MASK          = 511,
    parameter int          SPAWN_Y         = 0,
    parameter int          SPEED_DY        = 1,
    parameter int          COOLDOWN_CYCLES = 1000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input logic                      clk,
    input logic                      rst,
    game_sprite_spawn_ctrl_if.master bus
);
    localparam int            CW        = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CW-1:0] COOL_INIT = CW'(COOLDOWN_CYCLES - 1);

    spawn_state_e        state_q, state_d;
    logic                seen_q, seen_d;
    logic [CW-1:0]       cool_q, cool_d;
    logic                miss_d, kill_ack_d;
    logic [15:0]         lfsr_s, lfsr_next_s;
    logic [1:0]          dx_raw_s;

    logic                wxy_q, wdxy_q, en_q, active_q, miss_q, kill_ack_q;
    logic [w_x-1:0]      x_q;
    logic [w_y-1:0]      y_q;
    logic [DX_WIDTH-1:0] dx_q;
    logic [DY_WIDTH-1:0] dy_q;
    logic [7:0]          cnt_q;

    game_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr_s)
    );

    // Outputs are registered from the next state, so the LFSR word they capture is the one
    // visible during the strobe cycle itself.
    assign lfsr_next_s = lfsr_step(lfsr_s);
    assign dx_raw_s    = dx_decode(lfsr_next_s[1:0]);

    // Next-state, exit detection and cooldown countdown.
    always_comb begin
        state_d    = state_q;
        seen_d     = seen_q;
        cool_d     = cool_q;
        miss_d     = 1'b0;
        kill_ack_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.launch) state_d = ST_LOAD_XY;
                else            state_d = ST_IDLE;
            end
            ST_LOAD_XY:  state_d = ST_LOAD_DXY;
            ST_LOAD_DXY: begin
                state_d = ST_ACTIVE;
                seen_d  = 1'b0;
            end
            ST_ACTIVE: begin
                if (bus.sprite_within_screen) seen_d = 1'b1;
                else                          seen_d = seen_q;
                // Only a sprite already seen on screen can miss; kill takes priority.
                if (bus.kill) begin
                    kill_ack_d = 1'b1;
                    state_d    = ST_COOLDOWN;
                    cool_d     = COOL_INIT;
                end else if (seen_q && !bus.sprite_within_screen) begin
                    miss_d  = 1'b1;
                    state_d = ST_COOLDOWN;
                    cool_d  = COOL_INIT;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_COOLDOWN: begin
                if (cool_q == {CW{1'b0}}) begin
                    if (bus.auto_respawn) state_d = ST_LOAD_XY;
                    else                  state_d = ST_IDLE;
                end else begin
                    cool_d = cool_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State plus registered strobes, spawn data and saturating spawn counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            seen_q     <= 1'b0;
            cool_q     <= {CW{1'b0}};
            wxy_q      <= 1'b0;
            wdxy_q     <= 1'b0;
            en_q       <= 1'b0;
            active_q   <= 1'b0;
            miss_q     <= 1'b0;
            kill_ack_q <= 1'b0;
            x_q        <= {w_x{1'b0}};
            y_q        <= {w_y{1'b0}};
            dx_q       <= {DX_WIDTH{1'b0}};
            dy_q       <= {DY_WIDTH{1'b0}};
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            seen_q     <= seen_d;
            cool_q     <= cool_d;
            wxy_q      <= (state_d == ST_LOAD_XY);
            wdxy_q     <= (state_d == ST_LOAD_DXY);
            en_q       <= (state_d == ST_ACTIVE);
            active_q   <= (state_d == ST_ACTIVE);
            miss_q     <= miss_d;
            kill_ack_q <= kill_ack_d;
            if (state_d == ST_LOAD_XY) begin
                x_q <= w_x'(16'(SPAWN_X_MIN) + (lfsr_next_s & 16'(X_MASK)));
                y_q <= w_y'(SPAWN_Y);
                if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            end
            if (state_d == ST_LOAD_DXY) begin
                dx_q <= DX_WIDTH'($signed(dx_raw_s));
                dy_q <= DY_WIDTH'(SPEED_DY);
            end
        end
    end

    assign bus.sprite_write_xy      = wxy_q;
    assign bus.sprite_write_dxy     = wdxy_q;
    assign bus.sprite_write_x       = x_q;
    assign bus.sprite_write_y       = y_q;
    assign bus.sprite_write_dx      = dx_q;
    assign bus.sprite_write_dy      = dy_q;
    assign bus.sprite_enable_update = en_q;
    assign bus.active               = active_q;
    assign bus.miss                 = miss_q;
    assign bus.kill_ack             = kill_ack_q;
    assign bus.spawn_count          = cnt_q;
endmodule

// File: tb/tb_game_sprite_spawn_ctrl.sv
// Directed bench for the sprite spawn controller with an independent LFSR reference model.
module tb_game_sprite_spawn_ctrl;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [7:0]  exp_cnt;
    logic [15:0] m_lfsr;
    logic [9:0]  exp_x;
    logic [1:0]  exp_dx;
    int   bad;

    game_sprite_spawn_ctrl_if #(.W_X(10), .W_Y(9), .DX_WIDTH(2), .DY_WIDTH(2)) bus ();

    game_sprite_spawn_ctrl #(.COOLDOWN_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: right-shifting Galois, taps 0xB400, seed 0xACE1.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] model_x(input logic [15:0] l);
        logic [9:0] lo;
        lo = l[9:0];
        return 10'd32 + (lo & 10'd511);
    endfunction

    function automatic logic [1:0] model_dx(input logic [15:0] l);
        case (l[1:0])
            2'b01:   return 2'b01;
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'd255) ? 8'd255 : c + 8'd1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        bus.launch = 1'b0; bus.auto_respawn = 1'b0; bus.kill = 1'b0; bus.sprite_within_screen = 1'b0;
        exp_cnt = 8'd0;
        repeat (3) tick();
        n_total++;
        if ({bus.sprite_write_xy, bus.sprite_write_dxy, bus.sprite_write_x, bus.sprite_write_y,
             bus.sprite_write_dx, bus.sprite_write_dy, bus.sprite_enable_update, bus.active,
             bus.miss, bus.kill_ack} !== 27'd0)
            $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        else n_pass++;
        n_total++;
        if (bus.spawn_count !== 8'd0) $display("FAIL reset_count: got %0d required 0", bus.spawn_count);
        else n_pass++;
        rst = 1'b1;
        bad = 0;
        repeat (4) begin
            tick();
            if (bus.sprite_write_xy !== 1'b0 || bus.active !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL idle_quiet: got %0d busy cycles required 0", bad);
        else n_pass++;
    endtask

    task automatic test_spawn_latency();
        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        exp_x = model_x(m_lfsr);
        n_total++;
        if (bus.sprite_write_xy !== 1'b1 || bus.sprite_write_dxy !== 1'b0 || bus.sprite_enable_update !== 1'b0)
            $display("FAIL lat_xy: got xy=%b dxy=%b en=%b required 1 0 0", bus.sprite_write_xy, bus.sprite_write_dxy, bus.sprite_enable_update);
        else n_pass++;
        n_total++;
        if (bus.sprite_write_x !== exp_x || bus.sprite_write_y !== 9'd0)
            $display("FAIL spawn_xy: got x=%0d y=%0d required x=%0d y=0", bus.sprite_write_x, bus.sprite_write_y, exp_x);
        else n_pass++;
        n_total++;
        if (bus.spawn_count !== exp_cnt) $display("FAIL count_first: got %0d required %0d", bus.spawn_count, exp_cnt);
        else n_pass++;
        tick();
        exp_dx = model_dx(m_lfsr);
        n_total++;
        if (bus.sprite_write_dxy !== 1'b1 || bus.sprite_write_xy !== 1'b0)
            $display("FAIL lat_dxy: got xy=%b dxy=%b required 0 1", bus.sprite_write_xy, bus.sprite_write_dxy);
        else n_pass++;
        n_total++;
        if (bus.sprite_write_dx !== exp_dx || bus.sprite_write_dy !== 2'b01 || bus.sprite_write_x !== exp_x)
            $display("FAIL spawn_dxy: got dx=%b dy=%b x=%0d required dx=%b dy=01 x=%0d",
                     bus.sprite_write_dx, bus.sprite_write_dy, bus.sprite_write_x, exp_dx, exp_x);
        else n_pass++;
        tick();
        n_total++;
        if (bus.sprite_enable_update !== 1'b1 || bus.active !== 1'b1 || bus.sprite_write_dxy !== 1'b0)
            $display("FAIL lat_active: got en=%b act=%b dxy=%b required 1 1 0", bus.sprite_enable_update, bus.active, bus.sprite_write_dxy);
        else n_pass++;
    endtask

    task automatic test_miss_respawn();
        bus.sprite_within_screen = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.miss !== 1'b0 || bus.active !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL onscreen_hold: got %0d bad cycles required 0", bad);
        else n_pass++;
        bus.sprite_within_screen = 1'b0;
        bus.auto_respawn = 1'b1;
        tick();
        n_total++;
        if (bus.miss !== 1'b1 || bus.kill_ack !== 1'b0 || bus.sprite_enable_update !== 1'b0 || bus.active !== 1'b0)
            $display("FAIL miss_pulse: got miss=%b ack=%b en=%b act=%b required 1 0 0 0", bus.miss, bus.kill_ack, bus.sprite_enable_update, bus.active);
        else n_pass++;
        bad = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1 && bus.miss !== 1'b0) bad++;
            if (bus.sprite_write_xy !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL cooldown_quiet: got %0d bad cycles required 0", bad);
        else n_pass++;
        tick();
        exp_cnt = sat_inc(exp_cnt);
        exp_x = model_x(m_lfsr);
        n_total++;
        if (bus.sprite_write_xy !== 1'b1 || bus.sprite_write_x !== exp_x || bus.spawn_count !== exp_cnt)
            $display("FAIL respawn: got xy=%b x=%0d cnt=%0d required 1 %0d %0d", bus.sprite_write_xy, bus.sprite_write_x, bus.spawn_count, exp_x, exp_cnt);
        else n_pass++;
        bus.auto_respawn = 1'b0;
    endtask

    task automatic test_unseen_then_kill();
        tick();
        tick();
        bad = 0;
        repeat (100) begin
            tick();
            if (bus.miss !== 1'b0 || bus.active !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL unseen_no_miss: got %0d bad cycles required 0", bad);
        else n_pass++;
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        n_total++;
        if (bus.kill_ack !== 1'b1 || bus.miss !== 1'b0 || bus.active !== 1'b0)
            $display("FAIL kill_ack: got ack=%b miss=%b act=%b required 1 0 0", bus.kill_ack, bus.miss, bus.active);
        else n_pass++;
        tick();
        n_total++;
        if (bus.kill_ack !== 1'b0) $display("FAIL kill_ack_width: got %b required 0", bus.kill_ack);
        else n_pass++;
        bad = 0;
        repeat (6) begin
            tick();
            if (bus.sprite_write_xy !== 1'b0 || bus.active !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL to_idle: got %0d bad cycles required 0", bad);
        else n_pass++;
    endtask

    task automatic test_kill_and_exit();
        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        tick();
        tick();
        bus.sprite_within_screen = 1'b1;
        tick();
        bus.sprite_within_screen = 1'b0;
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        n_total++;
        if (bus.kill_ack !== 1'b1 || bus.miss !== 1'b0)
            $display("FAIL kill_priority: got ack=%b miss=%b required 1 0", bus.kill_ack, bus.miss);
        else n_pass++;
        repeat (6) tick();
    endtask

    task automatic test_ignored_launch();
        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        tick();
        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        n_total++;
        if (bus.active !== 1'b1 || bus.sprite_write_xy !== 1'b0)
            $display("FAIL launch_in_dxy: got act=%b xy=%b required 1 0", bus.active, bus.sprite_write_xy);
        else n_pass++;
        bus.sprite_within_screen = 1'b1;
        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        bus.sprite_within_screen = 1'b0;
        bus.launch = 1'b1;
        repeat (4) tick();
        bus.launch = 1'b0;
        bad = 0;
        repeat (6) begin
            tick();
            if (bus.sprite_write_xy !== 1'b0 || bus.active !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0 || bus.spawn_count !== exp_cnt)
            $display("FAIL launch_ignored: got %0d busy cycles cnt=%0d required 0 and %0d", bad, bus.spawn_count, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int n;
        bus.auto_respawn = 1'b1;
        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        bad = 0;
        for (int i = 0; i < 260; i++) begin
            n = 0;
            while (bus.sprite_write_xy !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            if (bus.sprite_write_xy !== 1'b1) bad++;
            exp_cnt = sat_inc(exp_cnt);
            if (bus.spawn_count !== exp_cnt) bad++;
            tick();
            tick();
            bus.kill = 1'b1;
            tick();
            bus.kill = 1'b0;
        end
        n_total++;
        if (bad != 0) $display("FAIL sat_sequence: got %0d bad spawns required 0", bad);
        else n_pass++;
        n_total++;
        if (bus.spawn_count !== 8'd255) $display("FAIL sat_count: got %0d required 255", bus.spawn_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_active();
        int n;
        n = 0;
        while (bus.sprite_write_xy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        bus.auto_respawn = 1'b0;
        n_total++;
        if (bus.active !== 1'b1) $display("FAIL pre_reset_active: got %b required 1", bus.active);
        else n_pass++;
        #3;
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.sprite_write_xy, bus.sprite_write_dxy, bus.sprite_write_x, bus.sprite_write_y,
             bus.sprite_write_dx, bus.sprite_write_dy, bus.sprite_enable_update, bus.active,
             bus.miss, bus.kill_ack, bus.spawn_count} !== 35'd0)
            $display("FAIL async_reset: got act=%b en=%b cnt=%0d required all 0", bus.active, bus.sprite_enable_update, bus.spawn_count);
        else n_pass++;
        tick();
        rst = 1'b1;
        exp_cnt = 8'd0;
        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        exp_x = model_x(m_lfsr);
        n_total++;
        if (bus.sprite_write_xy !== 1'b1 || bus.spawn_count !== exp_cnt || bus.sprite_write_x !== exp_x)
            $display("FAIL post_reset_spawn: got xy=%b cnt=%0d x=%0d required 1 %0d %0d", bus.sprite_write_xy, bus.spawn_count, bus.sprite_write_x, exp_cnt, exp_x);
        else n_pass++;
        tick();
        exp_dx = model_dx(m_lfsr);
        n_total++;
        if (bus.sprite_write_dxy !== 1'b1 || bus.sprite_write_dx !== exp_dx)
            $display("FAIL post_reset_dxy: got dxy=%b dx=%b required 1 %b", bus.sprite_write_dxy, bus.sprite_write_dx, exp_dx);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_spawn_latency();
        test_miss_respawn();
        test_unseen_then_kill();
        test_kill_and_exit();
        test_ignored_launch();
        test_saturation();
        test_reset_mid_active();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
